// File: rtl/spi_pkg.sv
// spi_pkg: shared states and constants for the SPI slave front end
package spi_pkg;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int RX_BITS = 10;
    localparam int TX_BITS = 8;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: loads a read word and shifts it onto MISO, MSB first
// Ports: clk, rst_n (async, active low); clr aborts; load/data start a transfer;
//        shift_en allows shifting; miso serial out; busy while shifting; done on the last bit.
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] data,
    output logic         miso,
    output logic         busy,
    output logic         done
);
    logic [W-1:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    logic busy_q, busy_d;
    // done marks the cycle showing the final bit; MISO drops to 0 at the next edge
    assign done = busy_q && shift_en && cnt_q == 4'(W - 1);
    assign miso = busy_q & sr_q[W-1];
    assign busy = busy_q;
    always_comb begin
        sr_d = sr_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        if (clr) begin
            sr_d = '0;
            cnt_d = '0;
            busy_d = 1'b0;
        end else if (load) begin
            sr_d = data;
            cnt_d = '0;
            busy_d = 1'b1;
        end else if (busy_q && shift_en) begin
            sr_d = sr_q << 1;
            cnt_d = done ? 4'd0 : cnt_q + 4'd1;
            busy_d = !done;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q <= sr_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end; deserialises command/data frames and serialises RAM read data
// Ports: clk, rst_n (async, active low); SS_n/MOSI serial in; MISO serial out;
//        rx_data/rx_valid word to the RAM; tx_data/tx_valid read data from the RAM.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    localparam int RXW = DATA_W + RX_BITS - TX_BITS;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [RXW-1:0] sr_q, sr_d, rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d, rx_done_q, rx_done_d;
    logic tx_done_q, tx_done_d, addr_seen_q, addr_seen_d;
    logic tx_load, tx_busy, tx_last;
    spi_tx_shifter #(.W(DATA_W)) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (SS_n),
        .load     (tx_load),
        .shift_en (state_q == READ_DATA),
        .data     (tx_data),
        .miso     (MISO),
        .busy     (tx_busy),
        .done     (tx_last)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        rx_data_d = rx_data_q;
        rx_valid_d = 1'b0;
        rx_done_d = rx_done_q;
        tx_done_d = tx_done_q;
        addr_seen_d = addr_seen_q;
        tx_load = 1'b0;
        if (SS_n) begin
            state_d = IDLE;
            cnt_d = '0;
            rx_done_d = 1'b0;
            tx_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d = '0;
                    rx_done_d = 1'b0;
                    tx_done_d = 1'b0;
                end
                CHK_CMD: begin
                    sr_d = {sr_q[RXW-2:0], MOSI};
                    cnt_d = 4'd1;
                    state_d = !MOSI ? WRITE : addr_seen_q ? READ_DATA : READ_ADD;
                end
                default: begin
                    if (!rx_done_q) begin
                        sr_d = {sr_q[RXW-2:0], MOSI};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'(RXW - 1)) begin
                            cnt_d = '0;
                            rx_done_d = 1'b1;
                            rx_valid_d = 1'b1;
                            rx_data_d = sr_d;
                            addr_seen_d = addr_seen_q | (state_q == READ_ADD);
                        end
                    end else if (state_q == READ_DATA && !tx_done_q) begin
                        // the frame is in; wait for the RAM reply, then stream it until done
                        tx_load = tx_valid && !tx_busy;
                        if (tx_last) begin
                            tx_done_d = 1'b1;
                            addr_seen_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sr_q <= '0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q <= 1'b0;
            tx_done_q <= 1'b0;
            addr_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sr_q <= sr_d;
            rx_data_q <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_done_q <= rx_done_d;
            tx_done_q <= tx_done_d;
            addr_seen_q <= addr_seen_d;
        end
    end
    assign rx_data = rx_data_q;
    assign rx_valid = rx_valid_q;
endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI-slave/single-port-RAM subsystem. It deserialises MOSI frames into 10-bit command/data words for the RAM (`rx_data`, `rx_valid`). On read-data commands it takes the RAM's 8-bit read result (`tx_data`, `tx_valid`) and serialises it onto MISO. It is a pure clk-domain FSM: SCK is modelled by `clk`, and MOSI/SS_n are sampled on rising `clk` edges.

## Interface
- `DATA_W`, default 8: RAM word/address width; `rx_data` is DATA_W+2 bits.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `SS_n` in 1: slave select, active low; frames a transaction.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial read data out, MSB first.
- `rx_data` out DATA_W+2: deserialised word; bits [9:8] are the command, bits [7:0] the payload.
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` in DATA_W: read data from the RAM.
- `tx_valid` in 1: qualifies `tx_data`; sampled only while waiting in READ_DATA.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `addr_seen`: set when a READ_ADD frame completes; cleared when a READ_DATA transfer completes its 8th MISO bit.
- IDLE: `SS_n`=0 at an edge moves to CHK_CMD; no bit is sampled at that edge.
- CHK_CMD: samples the first frame bit, which becomes `rx_data[9]`. Next state:
  - bit=0 → WRITE;
  - bit=1 and `addr_seen`=0 → READ_ADD;
  - bit=1 and `addr_seen`=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA shift in the remaining 9 bits, MSB first, into a 10-bit shift register.
- Command bits [9:8] are forwarded unchecked; the RAM decodes them.
- Frame completion: a registered `rx_valid`=1 for exactly one cycle, with `rx_data` holding the full word.
  - `rx_data` keeps that value until the next completed frame.
- After frame completion in WRITE or READ_ADD, further MOSI bits are ignored until `SS_n` rises.
- READ_DATA, after its frame: wait for `tx_valid`=1.
  - At that edge, load `tx_data` into the tx shifter and drive `MISO`=`tx_data[7]`.
  - Each following edge drives the next bit, for 8 bits in total.
  - Then `MISO` returns to 0, `addr_seen` clears, and the FSM holds until `SS_n` rises.
- `SS_n`=1 at any edge, in any state: go to IDLE, clear the bit counters, `MISO`=0, no `rx_valid`.
  - `addr_seen` and `rx_data` are preserved.
  - An aborted frame is discarded entirely.
- Reset (asynchronous, any time): state IDLE, `addr_seen`=0, `rx_data`=0, `rx_valid`=0, `MISO`=0, shift registers and counters 0.

## Timing
- Edge E0: IDLE sees `SS_n`=0.
- Edges E1..E10 sample b9..b0; E1 occurs in CHK_CMD.
- `rx_valid` is high in the cycle after E10 and drops after E11.
- The RAM registers its reply, so `tx_valid` arrives at earliest one cycle after `rx_valid` (sampled at E12).
- `MISO` bit 7 appears after the `tx_valid` edge; bits 6..0 follow on consecutive edges. The latency from `tx_valid` to the MISO MSB is 1 clk.
- `tx_valid` seen outside the READ_DATA wait phase is ignored.
- If `tx_valid` never arrives, the FSM stays waiting until `SS_n`=1 or reset.
- Bit counter: 4 bits, counts 0..9 for rx and 0..7 for tx, and does not wrap within a transaction.
- `SS_n` rising in the same cycle as the 10th bit: the abort wins, and there is no `rx_valid`.

## Structure
- Package `spi_pkg`:
  - `state_e` enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - `RX_BITS`=10, `TX_BITS`=8.
- One sub-module: `spi_tx_shifter` (load, shift-enable, done flag, MISO out). The rx path and FSM stay in `spi_slave`.

## Test plan
- Write address: SS_n low, MOSI 0000001010 → WRITE path; `rx_data`=10'h00A; `rx_valid` pulses one cycle after E10; `MISO` stays 0.
- Write data: MOSI 0101011010 → `rx_data`=10'h15A, single `rx_valid`; `addr_seen` unchanged (0).
- Read address: MOSI 1000001010 → READ_ADD; `rx_data`=10'h20A; `addr_seen`=1 after the frame.
- Read data: MOSI 1100000000, then `tx_valid`=1 with `tx_data`=8'h5A one cycle after `rx_valid` → `rx_data`=10'h300; MISO 0,1,0,1,1,0,1,0 on consecutive cycles, then 0; `addr_seen` cleared.
- Abort: SS_n raised after 5 bits of a write frame → no `rx_valid`, IDLE next cycle, `rx_data` keeps its old value. A following full frame decodes correctly.
- Reset mid read: `rst_n` low during MISO bit 3 → immediate `MISO`=0, `rx_valid`=0, state IDLE, `addr_seen`=0. The next read command goes to READ_ADD.
